// File: rtl/byte_encode12_pkg.sv
// Shared constants and state encoding for the ByteEncode12 packer.
package byte_encode12_pkg;
    localparam int KYBER_N         = 256;
    localparam int KYBER_POLYBYTES = 384;
    localparam int POLY_WORDS      = KYBER_POLYBYTES / 8;
    localparam int POLY_BEATS      = KYBER_N / 4;
    localparam int BUF_BYTES       = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PACK = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/byte_encode12_pair.sv
// Packs one 12-bit coefficient pair (a at the MSB end) into three stream bytes.
module encode12_pair (
    input  logic [23:0] i_pair,
    output logic [23:0] o_bytes
);
    logic [11:0] a;
    logic [11:0] b;

    assign a = i_pair[23:12];
    assign b = i_pair[11:0];
    assign o_bytes = {a[7:0], b[3:0], a[11:8], b[11:4]};
endmodule

// File: rtl/byte_encode12.sv
// ByteEncode12 gearbox: 4x12-bit coefficient beats in, 64-bit byte words out.
//  state  | meaning
//  S_IDLE | waiting for the first valid beat of a polynomial
//  S_PACK | accepting beats and emitting words until word 47 transfers
//  S_DONE | one-cycle done pulse, counters cleared on the way to S_IDLE
module byte_encode12
    import byte_encode12_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [47:0] i_coeffs,
    input  logic        i_coeffs_valid,
    output logic        o_coeffs_ready,
    output logic [63:0] o_obytes,
    output logic        o_obytes_valid,
    input  logic        i_obytes_ready,
    output logic        o_done
);
    state_t         state_q;
    logic [3:0]     fill_q, fill_d;
    logic [111:0]   buf_q, buf_d;
    logic [6:0]     cnt_in_q, cnt_in_d;
    logic [5:0]     cnt_out_q, cnt_out_d;
    logic [47:0]    beat_bytes;
    logic [111:0]   shifted;
    logic [3:0]     base;
    logic           push;
    logic           pop;
    logic           last_word;

    encode12_pair u_pair_lo (.i_pair(i_coeffs[47:24]), .o_bytes(beat_bytes[47:24]));
    encode12_pair u_pair_hi (.i_pair(i_coeffs[23:0]),  .o_bytes(beat_bytes[23:0]));

    assign o_obytes       = buf_q[111:48];
    assign o_obytes_valid = (state_q == S_PACK) && (fill_q >= 4'd8);
    assign o_coeffs_ready = (state_q == S_PACK) && (fill_q <= 4'd8)
                            && (cnt_in_q < 7'(POLY_BEATS));
    assign o_done         = (state_q == S_DONE);

    assign push      = i_coeffs_valid && o_coeffs_ready;
    assign pop       = o_obytes_valid && i_obytes_ready;
    assign last_word = pop && (cnt_out_q == 6'(POLY_WORDS - 1));

    // Bytes beyond fill are always zero, so new bytes can be OR-ed in at the tail.
    always_comb begin
        fill_d    = fill_q;
        buf_d     = buf_q;
        cnt_in_d  = cnt_in_q;
        cnt_out_d = cnt_out_q;
        shifted   = buf_q;
        base      = fill_q;
        if (state_q == S_PACK) begin
            if (pop) begin
                shifted = {buf_q[47:0], 64'd0};
                base    = fill_q - 4'd8;
                if (!last_word) begin
                    cnt_out_d = cnt_out_q + 6'd1;
                end
            end
            buf_d  = shifted;
            fill_d = base;
            if (push) begin
                buf_d    = shifted | ({beat_bytes, 64'd0} >> {base, 3'b000});
                fill_d   = base + 4'd6;
                cnt_in_d = cnt_in_q + 7'd1;
            end
        end else if (state_q == S_DONE) begin
            fill_d    = '0;
            buf_d     = '0;
            cnt_in_d  = '0;
            cnt_out_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (i_coeffs_valid) state_q <= S_PACK;
                S_PACK:  if (last_word) state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fill_q    <= '0;
            buf_q     <= '0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
        end else begin
            fill_q    <= fill_d;
            buf_q     <= buf_d;
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
        end
    end
endmodule

// File: tb/tb_byte_encode12.sv
// Directed bench for byte_encode12: fixed pattern, ramp, stalls, gaps, mid-frame reset, all-FFF.
module tb_byte_encode12;
    import byte_encode12_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [47:0] coeffs;
    logic        cvalid;
    logic        cready;
    logic [63:0] obytes;
    logic        ovalid;
    logic        oready;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_bytes [KYBER_POLYBYTES];
    logic [63:0] got [POLY_WORDS];

    byte_encode12 dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_coeffs       (coeffs),
        .i_coeffs_valid (cvalid),
        .o_coeffs_ready (cready),
        .o_obytes       (obytes),
        .o_obytes_valid (ovalid),
        .i_obytes_ready (oready),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] coef(input int mode, input int idx);
        logic [11:0] v;
        case (mode)
            0: case (idx % 4)
                   0: v = 12'h123;
                   1: v = 12'h456;
                   2: v = 12'h789;
                   default: v = 12'hABC;
               endcase
            1: v = 12'(idx);
            default: v = 12'hFFF;
        endcase
        return v;
    endfunction

    function automatic logic [47:0] beat_of(input int mode, input int b);
        return {coef(mode, 4*b), coef(mode, 4*b+1), coef(mode, 4*b+2), coef(mode, 4*b+3)};
    endfunction

    task automatic build_exp(input int mode);
        for (int p = 0; p < 128; p++) begin
            logic [11:0] a, b;
            a = coef(mode, 2*p);
            b = coef(mode, 2*p+1);
            exp_bytes[3*p]   = a[7:0];
            exp_bytes[3*p+1] = {b[3:0], a[11:8]};
            exp_bytes[3*p+2] = b[11:4];
        end
    endtask

    function automatic logic [63:0] exp_word(input int k);
        logic [63:0] w = '0;
        for (int j = 0; j < 8; j++) w = {w[55:0], exp_bytes[8*k+j]};
        return w;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_frame(input int mode, input bit gaps, input bit rstall);
        build_exp(mode);
        fork
            begin : drv
                for (int b = 0; b < POLY_BEATS; b++) begin
                    int n;
                    if (gaps) begin
                        while ($urandom_range(0, 2) == 0) begin
                            cvalid = 1'b0;
                            coeffs = 48'({$urandom(), $urandom()});
                            @(posedge clk); #1;
                        end
                    end
                    cvalid = 1'b1;
                    coeffs = beat_of(mode, b);
                    n = 0;
                    while (!cready && n < 1000) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (n >= 1000) begin
                        chk("drv_timeout", 64'(n), 64'd0);
                        break;
                    end
                    @(posedge clk); #1;
                end
                cvalid = 1'b0;
            end
            begin : mon
                int nw = 0;
                int cyc = 0;
                bit stalled = 1'b0;
                logic [63:0] held = '0;
                while (nw < POLY_WORDS && cyc < 5000) begin
                    logic v, r;
                    logic [63:0] w;
                    r = rstall ? 1'($urandom_range(0, 1)) : 1'b1;
                    oready = r;
                    v = ovalid;
                    w = obytes;
                    chk("done_low_in_frame", 64'(done), 64'd0);
                    chk("fill_le14", 64'(dut.fill_q <= 4'd14), 64'd1);
                    if (stalled) begin
                        chk("stall_word_hold", w, held);
                        chk("stall_valid_hold", 64'(v), 64'd1);
                    end
                    stalled = v && !r;
                    held = w;
                    @(posedge clk); #1;
                    cyc++;
                    if (v && r) begin
                        got[nw] = w;
                        chk($sformatf("word%0d_m%0d", nw, mode), w, exp_word(nw));
                        nw++;
                    end
                end
                chk("frame_word_count", 64'(nw), 64'(POLY_WORDS));
                oready = 1'b1;
                chk("done_pulse_high", 64'(done), 64'd1);
                @(posedge clk); #1;
                chk("done_pulse_low", 64'(done), 64'd0);
                chk("idle_after_done", 64'(dut.state_q), 64'(S_IDLE));
            end
        join
    endtask

    initial begin
        rstn   = 1'b0;
        cvalid = 1'b0;
        coeffs = '0;
        oready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obytes", obytes, 64'd0);
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_cready", 64'(cready), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Fixed beat {123,456,789,ABC}: 6-byte group 23 61 45 89 C7 AB.
        run_frame(0, 1'b0, 1'b0);
        chk("pat_w0", got[0], 64'h23614589C7AB2361);
        chk("pat_w1", got[1], 64'h4589C7AB23614589);
        chk("pat_w2", got[2], 64'hC7AB23614589C7AB);
        chk("pat_w47", got[47], 64'hC7AB23614589C7AB);

        // Ramp 0..255 without backpressure.
        run_frame(1, 1'b0, 1'b0);
        chk("ramp_w0", got[0], 64'h0010000230000450);
        chk("ramp_w47", got[47], 64'hB00FFCD00FFEF00F);

        // Ramp with random downstream stalls, then with input gaps as well.
        run_frame(1, 1'b0, 1'b1);
        chk("ramp_stall_w47", got[47], 64'hB00FFCD00FFEF00F);
        run_frame(1, 1'b1, 1'b1);
        chk("ramp_gap_w0", got[0], 64'h0010000230000450);

        // Abort a frame after 20 beats.
        begin
            int beats = 0;
            int n = 0;
            oready = 1'b1;
            while (beats < 20 && n < 2000) begin
                logic r;
                cvalid = 1'b1;
                coeffs = beat_of(1, beats);
                r = cready;
                @(posedge clk); #1;
                if (r) beats++;
                n++;
            end
            chk("abort_beats", 64'(beats), 64'd20);
            cvalid = 1'b0;
            rstn   = 1'b0;
            @(posedge clk); #1;
            chk("abort_obytes", obytes, 64'd0);
            chk("abort_ovalid", 64'(ovalid), 64'd0);
            chk("abort_cready", 64'(cready), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            chk("abort_state", 64'(dut.state_q), 64'(S_IDLE));
            chk("abort_fill", 64'(dut.fill_q), 64'd0);
            rstn = 1'b1;
            @(posedge clk); #1;
        end
        run_frame(1, 1'b0, 1'b0);
        chk("post_abort_w0", got[0], 64'h0010000230000450);
        chk("post_abort_w47", got[47], 64'hB00FFCD00FFEF00F);

        // All-FFF coefficients pass through unreduced.
        run_frame(2, 1'b0, 1'b1);
        for (int k = 0; k < POLY_WORDS; k++) begin
            chk($sformatf("fff_w%0d", k), got[k], 64'hFFFFFFFFFFFFFFFF);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
